// File: rtl/iob_regfile_mp_pkg.sv
// Shared types and helpers for the multi-port register file: clear-FSM
// state encoding and the byte-merge used by strobed writes and read bypass.
package iob_regfile_mp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/iob_regfile_mp_rport.sv
// One registered read port: decode + range check, optional write-first merge
// (IOB_REGFILE_MP_BYPASS_EN), output data and valid registers.
module iob_regfile_mp_rport
  import iob_regfile_mp_pkg::*;
#(
  parameter int N      = 8,
  parameter int W      = 32,
  parameter int ADDR_W = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N-1:0][W-1:0]   mem_i,
  input  logic                  r_en_i,
  input  logic [ADDR_W-1:0]     r_addr_i,
`ifdef IOB_REGFILE_MP_BYPASS_EN
  input  logic                  wr_ok_i,
  input  logic [ADDR_W-1:0]     w_addr_i,
  input  logic [W/8-1:0]        w_strb_i,
  input  logic [W-1:0]          w_data_i,
`endif
  output logic [W-1:0]          r_data_o,
  output logic                  r_valid_o
);

  logic [W-1:0] rd_word;
  logic [W-1:0] r_data_d, r_data_q;
  logic         r_valid_q;

  // Out-of-range addresses match no entry and read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N; i++)
      if (r_addr_i == ADDR_W'(i)) rd_word = mem_i[i];
`ifdef IOB_REGFILE_MP_BYPASS_EN
    if (wr_ok_i && (w_addr_i == r_addr_i))
      for (int b = 0; b < W/8; b++)
        rd_word[8*b +: 8] = byte_merge(rd_word[8*b +: 8], w_data_i[8*b +: 8], w_strb_i[b]);
`endif
  end

  always_comb begin
    r_data_d = r_en_i ? rd_word : r_data_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_data_q  <= r_data_d;
      r_valid_q <= r_en_i;
    end
  end

  assign r_data_o  = r_data_q;
  assign r_valid_o = r_valid_q;

endmodule

// File: rtl/iob_regfile_mp.sv
// Multi-read-port register file with byte-strobed writes and an N-cycle clear
// sweep. Define IOB_REGFILE_MP_BYPASS_EN for write-first read forwarding.
module iob_regfile_mp
  import iob_regfile_mp_pkg::*;
#(
  parameter  int N       = 8,
  parameter  int W       = 32,
  parameter  int R_PORTS = 2,
  localparam int ADDR_W  = $clog2(N),
  localparam int WSTRB_W = W/8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  output logic                      busy_o,
  input  logic                      w_en_i,
  input  logic [ADDR_W-1:0]         w_addr_i,
  input  logic [WSTRB_W-1:0]        w_strb_i,
  input  logic [W-1:0]              w_data_i,
  input  logic [R_PORTS-1:0]        r_en_i,
  input  logic [R_PORTS*ADDR_W-1:0] r_addr_i,
  output logic [R_PORTS*W-1:0]      r_data_o,
  output logic [R_PORTS-1:0]        r_valid_o
);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic [N-1:0][W-1:0]   mem_q, mem_d;
  logic                  wr_ok;

  assign wr_ok = w_en_i && !busy_o && (int'(w_addr_i) < N);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (clear_i) state_d = CLEAR;
      end
      CLEAR: begin
        if (cnt_q == ADDR_W'(N-1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == CLEAR);
  end

  // Writes are refused while sweeping, so the sweep zero never races a write.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < N; i++) begin
      if (wr_ok && (w_addr_i == ADDR_W'(i)))
        for (int b = 0; b < WSTRB_W; b++)
          mem_d[i][8*b +: 8] = byte_merge(mem_q[i][8*b +: 8], w_data_i[8*b +: 8], w_strb_i[b]);
      if ((state_q == CLEAR) && (cnt_q == ADDR_W'(i)))
        mem_d[i] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) mem_q <= '0;
    else       mem_q <= mem_d;
  end

  for (genvar p = 0; p < R_PORTS; p++) begin : g_rport
    iob_regfile_mp_rport #(
      .N      (N),
      .W      (W),
      .ADDR_W (ADDR_W)
    ) u_rport (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .mem_i     (mem_q),
      .r_en_i    (r_en_i[p]),
      .r_addr_i  (r_addr_i[p*ADDR_W +: ADDR_W]),
`ifdef IOB_REGFILE_MP_BYPASS_EN
      .wr_ok_i   (wr_ok),
      .w_addr_i  (w_addr_i),
      .w_strb_i  (w_strb_i),
      .w_data_i  (w_data_i),
`endif
      .r_data_o  (r_data_o[p*W +: W]),
      .r_valid_o (r_valid_o[p])
    );
  end

endmodule

// File: doc/iob_regfile_mp.md
IOB_REGFILE_MP -- requirements
Module: iob_regfile_mp

Interface
REQ-001 SHALL have parameter N, default 8: number of registers, N >= 2.
REQ-002 SHALL have parameter W, default 32: register width, a multiple of 8.
REQ-003 SHALL have parameter R_PORTS, default 2: number of independent read ports, >= 1.
REQ-004 SHALL derive localparams ADDR_W = $clog2(N) and WSTRB_W = W/8; these are not overridable.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk_i  in  1  clock, all state on rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 clear_i  in  1  single-cycle request to zero the whole file.
REQ-008 busy_o  out  1  high while a clear sweep runs.
REQ-009 w_en_i  in  1  write request.
REQ-010 w_addr_i  in  ADDR_W  write register index.
REQ-011 w_strb_i  in  WSTRB_W  byte enables, bit b covers data bits [8b+7:8b].
REQ-012 w_data_i  in  W  write data.
REQ-013 r_en_i  in  R_PORTS  per-port read request.
REQ-014 r_addr_i  in  R_PORTS*ADDR_W  port p index at [p*ADDR_W+:ADDR_W].
REQ-015 r_data_o  out  R_PORTS*W  port p data at [p*W+:W], registered.
REQ-016 r_valid_o  out  R_PORTS  per-port one-cycle pulse qualifying r_data_o.

Function
REQ-017 Write: w_en_i=1 and busy_o=0 at edge k updates only the strobed bytes of register w_addr_i; the change is visible from edge k+1.
REQ-018 A write with w_addr_i >= N, or with busy_o=1, SHALL be dropped without side effects.
REQ-019 Read: r_en_i[p]=1 at edge k loads r_data_o[p] and sets r_valid_o[p]=1 for the cycle after edge k (1-cycle latency).
REQ-020 r_valid_o[p] SHALL fall at the next edge when r_en_i[p]=0. r_data_o[p] SHALL hold its last value.
REQ-021 A read with r_addr >= N SHALL return all zeros with r_valid_o[p]=1.
REQ-022 All ports SHALL read independently in the same cycle, including the same address.
REQ-023 Reads SHALL proceed normally during a clear sweep and return the current, partially cleared contents.
REQ-024 Clear FSM states: IDLE and CLEAR. IDLE->CLEAR when clear_i=1. CLEAR->IDLE after the register at index N-1 is zeroed.
REQ-025 In CLEAR, the ADDR_W-bit sweep counter SHALL start at 0 and zero register[cnt] each cycle, taking exactly N cycles. busy_o = (state==CLEAR).
REQ-026 clear_i SHALL be ignored while in CLEAR.
REQ-027 A write accepted in the same cycle as clear_i (busy_o still 0) SHALL be performed and is later zeroed by the sweep.

Reset
REQ-028 rst_i=1 at an edge SHALL zero all registers, r_data_o, r_valid_o and the sweep counter, and force IDLE (busy_o=0). This includes mid-sweep, which aborts.
REQ-029 rst_i SHALL take priority over clear_i, w_en_i and r_en_i in the same cycle.

Configuration
REQ-030 With macro IOB_REGFILE_MP_BYPASS_EN defined: a read and an accepted write to the same address in the same cycle SHALL return the old data with the strobed bytes replaced by w_data_i (write-first).
REQ-031 Without IOB_REGFILE_MP_BYPASS_EN: that read SHALL return the pre-write contents (read-first), and no forwarding logic is built.

Structure
REQ-032 Package iob_regfile_mp_pkg SHALL hold the FSM state encoding (IDLE=1'b0, CLEAR=1'b1) and the byte-merge function used for strobed writes and bypass.
REQ-033 Sub-module iob_regfile_mp_rport (address decode, range check, optional bypass merge, output and valid registers) SHALL be instantiated R_PORTS times by a generate loop.

Verification
REQ-034 N=8, W=32: write 0xDEADBEEF to reg 3 with strb 0xF, then write 0x000000AA with strb 0x1; read reg 3 on port 0 -> r_data_o=0xDEADBEAA, valid one cycle later.
REQ-035 Same-cycle write of 0x11223344 (strb 0xF) to reg 5 and read of reg 5 on port 1 -> 0x11223344 with BYPASS_EN, 0x00000000 without it.
REQ-036 Fill all 8 registers with 0xFF, pulse clear_i -> busy_o high for exactly 8 cycles, a write during busy is dropped, all reads return 0 afterwards.
REQ-037 Reset asserted at sweep cycle 3 -> busy_o=0, all registers and outputs 0 on the next cycle.
REQ-038 N=6: write to index 7 is dropped, and a read of index 7 returns 0 with r_valid_o=1. Both ports read reg 2 simultaneously and return identical data.
